// File: rtl/snd_pkg.sv
// snd_pkg: shared IRQ state encoding and default sizing
// for the sound command mailbox.
package snd_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT   = 2'd1,
    WAIT_ACK = 2'd2
  } irq_state_e;

  localparam int SND_IRQ_HOLD   = 4;
  localparam int SND_FIFO_DEPTH = 4;

endpackage

// File: rtl/snd_cmd_fifo.sv
// snd_cmd_fifo: command queue. SND_CMD_FIFO_EN selects a DEPTH-entry
// FIFO; otherwise a single overwritable register.
module snd_cmd_fifo
  import snd_pkg::*;
#(
  parameter int DEPTH = SND_FIFO_DEPTH
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

`ifdef SND_CMD_FIFO_EN
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop, do_push;

  // A pop frees a slot, so a push into a full queue is kept then.
  always_comb begin
    do_pop   = pop && (cnt_q != '0);
    do_push  = push && ((cnt_q != CW'(DEPTH)) || do_pop);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push && !reset) mem_q[wr_ptr_q] <= din;
  end

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign dout  = empty ? 8'h00 : mem_q[rd_ptr_q];
`else
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       unused_depth;

  assign unused_depth = |DEPTH;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (pop) valid_d = 1'b0;
    if (push) begin
      data_d  = din;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign empty = !valid_q;
  assign full  = valid_q;
  assign dout  = valid_q ? data_q : 8'h00;
`endif

endmodule

// File: rtl/snd_cmd_mailbox.sv
// snd_cmd_mailbox: main-to-audio CPU sound latch with IRQ handshake.
// Define SND_CMD_FIFO_EN for a FIFO_DEPTH-deep command queue.
module snd_cmd_mailbox
  import snd_pkg::*;
#(
  parameter int IRQ_HOLD   = SND_IRQ_HOLD,
  parameter int FIFO_DEPTH = SND_FIFO_DEPTH
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       acpu_clk_en,
  input  logic       wr_stb,
  input  logic [7:0] wr_data,
  input  logic       rd_stb,
  output logic [7:0] rd_data,
  output logic       irq_n,
  output logic       pending,
  output logic       overflow
);

  localparam int HW = $clog2(IRQ_HOLD + 1);

  irq_state_e    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          irq_n_q, irq_n_d;
  logic          ovf_q, ovf_d;
  logic          empty, full;

  snd_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_sys(clk_sys),
    .reset  (reset),
    .push   (wr_stb),
    .pop    (rd_stb),
    .din    (wr_data),
    .dout   (rd_data),
    .empty  (empty),
    .full   (full)
  );

  // An IDLE tick coinciding with an ack waits one tick so the
  // IRQ never fires for a command popped in that same cycle.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    irq_n_d = irq_n_q;
    ovf_d   = ovf_q | (wr_stb && full && !rd_stb);
    unique case (state_q)
      IDLE: begin
        if (acpu_clk_en && !empty && !rd_stb) begin
          state_d = ASSERT;
          irq_n_d = 1'b0;
          hold_d  = '0;
        end
      end
      ASSERT: begin
        if (rd_stb) begin
          state_d = IDLE;
          irq_n_d = 1'b1;
        end else if (acpu_clk_en) begin
          if (hold_q == HW'(IRQ_HOLD - 1)) begin
            state_d = WAIT_ACK;
            irq_n_d = 1'b1;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      WAIT_ACK: begin
        if (rd_stb) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        irq_n_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      irq_n_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      irq_n_q <= irq_n_d;
      ovf_q   <= ovf_d;
    end
  end

  assign irq_n    = irq_n_q;
  assign pending  = !empty;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_snd_cmd_mailbox.sv
// tb_snd_cmd_mailbox: directed scenarios plus randomized traffic
// checked against a queue model and IRQ pulse rules.
module tb_snd_cmd_mailbox;
  import snd_pkg::*;

  localparam int HOLD = SND_IRQ_HOLD;
`ifdef SND_CMD_FIFO_EN
  localparam int CAP = SND_FIFO_DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       acpu_clk_en = 1'b0;
  logic       wr_stb = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_stb = 1'b0;
  logic [7:0] rd_data;
  logic       irq_n, pending, overflow;

  snd_cmd_mailbox #(
    .IRQ_HOLD  (HOLD),
    .FIFO_DEPTH(SND_FIFO_DEPTH)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .acpu_clk_en(acpu_clk_en),
    .wr_stb     (wr_stb),
    .wr_data    (wr_data),
    .rd_stb     (rd_stb),
    .rd_data    (rd_data),
    .irq_n      (irq_n),
    .pending    (pending),
    .overflow   (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         pulses = 0;
  bit         mon_en = 0;
  bit         m_ovf = 0;
  logic [7:0] mq[$];
  logic [7:0] expq[$];

  task automatic chk(input bit ok, input string nm,
                     input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic bit en_next();
    return (cyc % 3) == 0;
  endfunction

  // Drive one cycle; the model follows the queue rules at the edge.
  task automatic step(input bit w, input logic [7:0] d,
                      input bit r, input bit rst = 1'b0);
    reset       = rst;
    wr_stb      = w;
    wr_data     = d;
    rd_stb      = r;
    acpu_clk_en = en_next();
    if (r && !rst && mq.size() > 0) expq.push_back(mq[0]);
    @(posedge clk_sys);
    cyc++;
    if (rst) begin
      mq.delete();
      m_ovf = 0;
    end else begin
      if (r && mq.size() > 0) void'(mq.pop_front());
      if (w) begin
        if (mq.size() < CAP) mq.push_back(d);
        else begin
          m_ovf = 1;
          if (CAP == 1) mq[0] = d;
        end
      end
    end
    #1;
    reset  = 1'b0;
    wr_stb = 1'b0;
    rd_stb = 1'b0;
  endtask

  task automatic wait_irq(input logic lvl, input int bound,
                          input string nm);
    int n = 0;
    while (irq_n !== lvl && n < bound) begin
      step(0, 8'h00, 0);
      n++;
    end
    chk(irq_n === lvl, nm, int'(irq_n), int'(lvl));
  endtask

  task automatic do_reset();
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);
  endtask

  bit prev_irq = 1, prev_en = 0, prev_pend = 0, prev_rst = 1;
  bit acked = 0;
  int lo = 0, hi = 0;

  // Monitor: model state, scoreboard pops on reads, IRQ pulse shape.
  always @(negedge clk_sys) begin
    if (mon_en) begin
      logic [7:0] hd;
      hd = (mq.size() > 0) ? mq[0] : 8'h00;
      chk(pending === (mq.size() != 0), "pending",
          int'(pending), int'(mq.size() != 0));
      chk(overflow === m_ovf, "overflow", int'(overflow), int'(m_ovf));
      chk(rd_data === hd, "rd_head", int'(rd_data), int'(hd));
      if (rd_stb && !reset && expq.size() > 0) begin
        logic [7:0] e;
        e = expq.pop_front();
        chk(rd_data === e, "sb_read", int'(rd_data), int'(e));
      end
      if (!irq_n && prev_irq) begin
        chk(prev_pend && prev_en && !prev_rst && hi >= 1,
            "irq_start", hi, 1);
        pulses++;
        lo    = 0;
        acked = 0;
      end
      if (irq_n && !prev_irq) begin
        chk(acked || lo == HOLD, "irq_len", lo, HOLD);
        hi = 0;
      end
      if (!irq_n) begin
        if (acpu_clk_en) lo++;
        if (rd_stb || reset) acked = 1;
        chk(lo <= HOLD, "irq_too_long", lo, HOLD);
      end else if (acpu_clk_en) begin
        hi++;
      end
    end
    prev_irq  = (irq_n !== 1'b0);
    prev_en   = acpu_clk_en;
    prev_pend = (mq.size() != 0);
    prev_rst  = reset;
  end

  initial begin
    int p0;
    int t;
    int n;
    logic [7:0] last;

    do_reset();
    chk(irq_n === 1'b1, "rst_irq_n", int'(irq_n), 1);
    chk(pending === 1'b0, "rst_pending", int'(pending), 0);
    chk(overflow === 1'b0, "rst_overflow", int'(overflow), 0);
    chk(rd_data === 8'h00, "rst_rd_data", int'(rd_data), 0);
    mon_en = 1;

    // Single command
    p0 = pulses;
    step(1, 8'h5A, 0);
    wait_irq(1'b0, 40, "single_irq_low");
    wait_irq(1'b1, 40, "single_irq_high");
    chk(rd_data === 8'h5A, "single_data", int'(rd_data), 8'h5A);
    step(0, 8'h00, 1);
    for (int i = 0; i < 20; i++) step(0, 8'h00, 0);
    chk(pending === 1'b0, "single_pend_clr", int'(pending), 0);
    chk(pulses == p0 + 1, "single_pulses", pulses, p0 + 1);

    // Same byte twice -> two IRQs
    p0 = pulses;
    for (int k = 0; k < 2; k++) begin
      step(1, 8'h11, 0);
      wait_irq(1'b0, 40, "repeat_irq_low");
      wait_irq(1'b1, 40, "repeat_irq_high");
      step(0, 8'h00, 1);
    end
    chk(pulses == p0 + 2, "repeat_pulses", pulses, p0 + 2);

`ifdef SND_CMD_FIFO_EN
    do_reset();
    for (int i = 1; i <= 5; i++) step(1, 8'(i), 0);
    chk(overflow === 1'b1, "full_overflow", int'(overflow), 1);
    for (int i = 1; i <= 4; i++) begin
      chk(rd_data === 8'(i), "full_order", int'(rd_data), i);
      step(0, 8'h00, 1);
    end
    chk(pending === 1'b0, "full_drained", int'(pending), 0);
`else
    do_reset();
    step(1, 8'h22, 0);
    step(1, 8'h33, 0);
    chk(rd_data === 8'h33, "reg_overwrite", int'(rd_data), 8'h33);
    chk(overflow === 1'b1, "reg_overflow", int'(overflow), 1);
    step(0, 8'h00, 1);
    chk(pending === 1'b0, "reg_one_read", int'(pending), 0);
`endif

    // Simultaneous push and pop
    do_reset();
    step(1, 8'hA0, 0);
    step(1, 8'hB0, 1);
    chk(pending === 1'b1, "simul_pending", int'(pending), 1);
    chk(rd_data === 8'hB0, "simul_data", int'(rd_data), 8'hB0);
    chk(overflow === 1'b0, "simul_overflow", int'(overflow), 0);

    // Reset on the 2nd hold tick
    do_reset();
    step(1, 8'h77, 0);
    wait_irq(1'b0, 40, "midrst_irq_low");
    t = 0;
    n = 0;
    while (n < 50) begin
      if (en_next() && !irq_n) t++;
      if (t == 2) break;
      step(0, 8'h00, 0);
      n++;
    end
    step(0, 8'h00, 0, 1);
    chk(irq_n === 1'b1, "midrst_irq_n", int'(irq_n), 1);
    chk(pending === 1'b0, "midrst_pending", int'(pending), 0);
    p0 = pulses;
    for (int i = 0; i < 30; i++) step(0, 8'h00, 0);
    chk(pulses == p0, "midrst_no_irq", pulses, p0);
    step(1, 8'h78, 0);
    wait_irq(1'b0, 40, "midrst_next_irq");
    step(0, 8'h00, 1);

    // Randomized traffic
    last = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      bit w, r, rs;
      logic [7:0] d;
      w  = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 5) == 0);
      rs = ($urandom_range(0, 399) == 0);
      d  = ($urandom_range(0, 3) == 0) ? last : 8'($urandom_range(0, 255));
      if (w) last = d;
      step(w, d, r, rs);
    end

    step(0, 8'h00, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
